// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package switch_debounce_pkg;

  typedef enum logic [0:0] {
    StStable,
    StPending
  } deb_state_e;

  localparam int unsigned ClkFreqHz  = 25000;
  localparam int unsigned DebounceMs = 10;
  // 10 ms at the 25 kHz board clock
  localparam int unsigned DefaultDebounceCycles = (ClkFreqHz / 1000) * DebounceMs;

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: input synchronizer followed by a stable/pending debounce FSM.
module debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_stable,
  output logic update
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign sw_stable = stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= StStable;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    unique case (state_q)
      StStable: begin
        if (sync != stable_q) begin
          state_d = StPending;
          cnt_d   = CntW'(1);
        end
      end
      StPending: begin
        if (sync == stable_q) begin
          // input bounced back before the window elapsed
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
          stable_d = sync;
          cnt_d    = '0;
          state_d  = StStable;
          update   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StStable;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch levels plus a registered any-change strobe.
// Define SWITCH_DEBOUNCE_EDGE_EN to add per-channel sw_rise/sw_fall strobes.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned N_SW            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic            sel_change
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
`endif
);

  logic [N_SW-1:0] update;
  logic            sel_change_q;

  for (genvar g = 0; g < N_SW; g++) begin : gen_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw[g]),
      .sw_stable(sw_stable[g]),
      .update   (update[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_change_q <= 1'b0;
    end else begin
      sel_change_q <= |update;
    end
  end

  assign sel_change = sel_change_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [N_SW-1:0] sw_rise_q, sw_fall_q;

  // An update always flips the level, so the old level gives the direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rise_q <= '0;
      sw_fall_q <= '0;
    end else begin
      sw_rise_q <= update & ~sw_stable;
      sw_fall_q <= update & sw_stable;
    end
  end

  assign sw_rise = sw_rise_q;
  assign sw_fall = sw_fall_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce against a run-length reference model.
module tb_switch_debounce;

  localparam int unsigned N = 2;
  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_stable;
  logic         sel_change;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
`endif

  switch_debounce #(
    .N_SW           (N),
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sel_change(sel_change)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a level is accepted once the synchronized input has disagreed
  // with it for D+1 consecutive samples; the synchronized input is the raw
  // value sampled S edges earlier.
  logic [N-1:0] hist [S];
  int           run  [N];
  logic [N-1:0] m_stable, m_rise, m_fall;
  logic         m_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < S; j++) hist[j] = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_sel    = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] raw);
    logic [N-1:0] prev;
    logic [N-1:0] seen;
    prev = m_stable;
    seen = hist[S-1];
    for (int i = 0; i < N; i++) begin
      if (seen[i] != m_stable[i]) begin
        run[i]++;
        if (run[i] == int'(D) + 1) begin
          m_stable[i] = seen[i];
          run[i]      = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    for (int j = S - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = raw;
    m_sel  = (m_stable != prev);
    m_rise = m_stable & ~prev;
    m_fall = ~m_stable & prev;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".stable"}, 32'(sw_stable), 32'(m_stable));
    check({tag, ".sel"}, 32'(sel_change), 32'(m_sel));
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    check({tag, ".rise"}, 32'(sw_rise), 32'(m_rise));
    check({tag, ".fall"}, 32'(sw_fall), 32'(m_fall));
`endif
  endtask

  // Called at a falling edge; drives raw, steps one clock, checks, returns at next falling edge
  task automatic cycle(input string tag, input logic [N-1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    #1;
    if (rst_n) model_step(raw);
    else model_reset();
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic hold(input string tag, input logic [N-1:0] raw, input int n);
    for (int c = 0; c < n; c++) cycle(tag, raw);
  endtask

  task automatic reset_pulse(input string tag, input logic [N-1:0] raw, input int n);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(negedge clk);
    hold(tag, raw, n);
    rst_n = 1'b1;
  endtask

  initial begin
    int           hcnt[N];
    logic [N-1:0] r;

    rst_n  = 1'b0;
    sw_raw = '1;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    hold("reset", 2'b11, 3);
    rst_n = 1'b1;
    hold("post_reset", 2'b11, 10);

    hold("settle", 2'b00, 10);
    hold("clean_rise", 2'b01, 10);
    hold("clean_fall", 2'b00, 10);

    hold("bounce3", 2'b10, 3);
    hold("bounce3", 2'b00, 10);
    hold("bounce5", 2'b10, 5);
    hold("bounce5", 2'b00, 12);

    hold("simul", 2'b11, 10);
    hold("simul", 2'b00, 10);

    hold("rst_mid", 2'b01, 4);
    reset_pulse("rst_mid", 2'b01, 2);
    hold("rst_mid", 2'b01, 10);
    hold("rst_mid", 2'b00, 10);

    for (int c = 0; c < 20; c++) cycle("toggle", (c % 2 == 0) ? 2'b11 : 2'b00);
    hold("toggle", 2'b00, 8);

    for (int i = 0; i < N; i++) hcnt[i] = 0;
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hcnt[i] == 0) begin
          r[i]    = 1'($urandom_range(0, 1));
          hcnt[i] = int'($urandom_range(1, 9));
        end
        hcnt[i]--;
      end
      if ($urandom_range(0, 299) == 0) reset_pulse("rand_rst", r, 1);
      else cycle("rand", r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
